rvx_core_store_buffer: RTL and testbench
========================================

RVX_CORE_STORE_BUFFER -- requirements
Module: rvx_core_store_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4: number of buffer entries; legal values are powers of two, 2 to 16.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port store_valid_s1, input, 1 bit: a store is offered this cycle.
REQ-005 The block SHALL have port store_address_s1, input, 32 bits: byte address of the store.
REQ-006 The block SHALL have port store_data_s1, input, 32 bits: lane-aligned store data from the store unit.
REQ-007 The block SHALL have port store_strobe_s1, input, 4 bits: byte-lane write strobe from the store unit.
REQ-008 The block SHALL have port store_ready_s1, output, 1 bit: the buffer can accept a store.
REQ-009 The block SHALL have port load_address_s1, input, 32 bits: byte address of a concurrent load.
REQ-010 The block SHALL have port load_hazard_s1, output, 1 bit: a buffered store overlaps the load's word.
REQ-011 The block SHALL have port mem_write_request, output, 1 bit: the head entry is presented to memory.
REQ-012 The block SHALL have port mem_address, output, 32 bits: word-aligned address of the head entry.
REQ-013 The block SHALL have port mem_write_data, output, 32 bits: data of the head entry.
REQ-014 The block SHALL have port mem_write_strobe, output, 4 bits: strobe of the head entry.
REQ-015 The block SHALL have port mem_ready, input, 1 bit: memory accepts the presented write this cycle.
REQ-016 The block SHALL have port buffer_empty, output, 1 bit: no entries are held; used for fence and drain.

Function
REQ-017 The block SHALL be a circular FIFO of DEPTH entries, each holding {address[31:2], data[31:0], strobe[3:0]}, with read and write pointers of log2(DEPTH) bits and a count of log2(DEPTH)+1 bits.
REQ-018 store_ready_s1 SHALL equal (count != DEPTH); it is combinational from registered state only and independent of mem_ready.
REQ-019 A push SHALL occur when store_valid_s1 && store_ready_s1 && (store_strobe_s1 != 4'b0000); a store with a zero strobe is dropped and leaves the state unchanged.
REQ-020 A pop SHALL occur when mem_write_request && mem_ready.
REQ-021 mem_write_request SHALL equal !buffer_empty; buffer_empty SHALL equal (count == 0).
REQ-022 While not empty, mem_address SHALL be {head.address, 2'b00}, with mem_write_data = head.data and mem_write_strobe = head.strobe; while empty, all three SHALL be 0.
REQ-023 Head outputs SHALL stay stable while mem_write_request=1 and mem_ready=0.
REQ-024 Push-to-request latency SHALL be exactly 1 cycle: there is no combinational bypass from the store inputs to the mem outputs.
REQ-025 A simultaneous push and pop SHALL leave count unchanged and advance both pointers; when full, no push occurs even if a pop occurs in the same cycle.
REQ-026 Pointers SHALL wrap modulo DEPTH; a pop when empty and a push when full are impossible by construction.
REQ-027 load_hazard_s1 SHALL be combinational: 1 if any valid entry has address == load_address_s1[31:2] and a nonzero strobe, otherwise 0.
REQ-028 The entry being popped in the current cycle SHALL still count toward load_hazard_s1.
REQ-029 Entries SHALL drain in strict FIFO order, and each entry SHALL be written to memory exactly once.

Reset
REQ-030 On reset_n=0, the block SHALL asynchronously clear count and both pointers, giving store_ready_s1=1, buffer_empty=1, mem_write_request=0, mem_address=0, mem_write_data=0, mem_write_strobe=0 and load_hazard_s1=0.
REQ-031 Entry storage contents need not be reset.
REQ-032 Reset asserted mid-drain SHALL discard all pending entries without any further memory write.
REQ-033 The first push SHALL be possible on the first rising clock edge after reset_n deasserts.

Verification
REQ-034 Single store (addr 0x1003, data 0xAB000000, strobe 4'b1000, mem_ready=1) -> next cycle: mem_write_request=1, mem_address=0x1000, mem_write_strobe=4'b1000; one cycle later: buffer_empty=1.
REQ-035 DEPTH=4 with mem_ready=0, push 5 consecutive stores -> store_ready_s1=0 after the 4th; the 5th is not accepted; with mem_ready=1, the 4 stores drain in order.
REQ-036 Full buffer, store_valid_s1=1 and mem_ready=1 in the same cycle -> pop only, count=3; the push succeeds next cycle and count returns to 4.
REQ-037 Buffered store to 0x2004, load_address_s1=0x2006 -> load_hazard_s1=1; load_address_s1=0x2008 -> load_hazard_s1=0; after the pop completes -> 0x2006 gives load_hazard_s1=0.
REQ-038 store_valid_s1=1 with strobe 4'b0000 -> no push; buffer_empty stays 1.
REQ-039 3 entries pending, reset_n pulsed low between clock edges -> outputs clear immediately; no mem write occurs after reset_n deasserts.

Source files
------------

// File: rtl/rvx_core_store_buffer.sv
// Post-commit store buffer: a small circular FIFO that holds retired stores
// until memory accepts them, and flags loads that overlap a pending store word.
module rvx_core_store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        store_valid_s1,
  input  logic [31:0] store_address_s1,
  input  logic [31:0] store_data_s1,
  input  logic [3:0]  store_strobe_s1,
  output logic        store_ready_s1,
  input  logic [31:0] load_address_s1,
  output logic        load_hazard_s1,
  output logic        mem_write_request,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_write_strobe,
  input  logic        mem_ready,
  output logic        buffer_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [29:0] entry_addr_q [DEPTH];
  logic [29:0] entry_addr_d [DEPTH];
  logic [31:0] entry_data_q [DEPTH];
  logic [31:0] entry_data_d [DEPTH];
  logic [3:0]  entry_strb_q [DEPTH];
  logic [3:0]  entry_strb_d [DEPTH];

  logic full;
  logic push;
  logic pop;

  assign full              = (count_q == CNT_W'(DEPTH));
  assign buffer_empty      = (count_q == '0);
  assign store_ready_s1    = !full;
  assign mem_write_request = !buffer_empty;

  // Zero-strobe stores carry no bytes, so they are dropped rather than queued.
  assign push = store_valid_s1 && store_ready_s1 && (store_strobe_s1 != 4'b0000);
  assign pop  = mem_write_request && mem_ready;

  // The head outputs come only from registered state, so a push becomes
  // visible to memory one cycle later and the head is stable while stalled.
  assign mem_address      = buffer_empty ? 32'h0 : {entry_addr_q[rd_ptr_q], 2'b00};
  assign mem_write_data   = buffer_empty ? 32'h0 : entry_data_q[rd_ptr_q];
  assign mem_write_strobe = buffer_empty ? 4'h0  : entry_strb_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    entry_addr_d = entry_addr_q;
    entry_data_d = entry_data_q;
    entry_strb_d = entry_strb_q;
    if (push) begin
      entry_addr_d[wr_ptr_q] = store_address_s1[31:2];
      entry_data_d[wr_ptr_q] = store_data_s1;
      entry_strb_d[wr_ptr_q] = store_strobe_s1;
    end
  end

  // An entry is live when its distance from the read pointer is below count;
  // the entry leaving this cycle is still live, so it still raises a hazard.
  always_comb begin
    logic [PTR_W-1:0] offset;
    offset         = '0;
    load_hazard_s1 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = PTR_W'(i) - rd_ptr_q;
      if (({1'b0, offset} < count_q) &&
          (entry_addr_q[i] == load_address_s1[31:2]) &&
          (entry_strb_q[i] != 4'b0000)) begin
        load_hazard_s1 = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry payloads are qualified by count, so they need no reset.
  always_ff @(posedge clock) begin
    entry_addr_q <= entry_addr_d;
    entry_data_q <= entry_data_d;
    entry_strb_q <= entry_strb_d;
  end

endmodule

// File: tb/tb_rvx_core_store_buffer.sv
// Directed bench for rvx_core_store_buffer: a vector table for single-entry
// behaviour plus hand sequences for fill/wrap, full push+pop and mid-drain reset.
module tb_rvx_core_store_buffer;

  logic        clock;
  logic        reset_n;
  logic        store_valid_s1;
  logic [31:0] store_address_s1;
  logic [31:0] store_data_s1;
  logic [3:0]  store_strobe_s1;
  logic        store_ready_s1;
  logic [31:0] load_address_s1;
  logic        load_hazard_s1;
  logic        mem_write_request;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_write_strobe;
  logic        mem_ready;
  logic        buffer_empty;

  int passedCount = 0;
  int totalCount  = 0;

  rvx_core_store_buffer #(.DEPTH(4)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .store_valid_s1    (store_valid_s1),
    .store_address_s1  (store_address_s1),
    .store_data_s1     (store_data_s1),
    .store_strobe_s1   (store_strobe_s1),
    .store_ready_s1    (store_ready_s1),
    .load_address_s1   (load_address_s1),
    .load_hazard_s1    (load_hazard_s1),
    .mem_write_request (mem_write_request),
    .mem_address       (mem_address),
    .mem_write_data    (mem_write_data),
    .mem_write_strobe  (mem_write_strobe),
    .mem_ready         (mem_ready),
    .buffer_empty      (buffer_empty)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        sv;
    logic [31:0] sa;
    logic [31:0] sd;
    logic [3:0]  ss;
    logic [31:0] la;
    logic        mr;
    logic        eReady;
    logic        eHaz;
    logic        eReq;
    logic [31:0] eAddr;
    logic [31:0] eData;
    logic [3:0]  eStrb;
    logic        eEmpty;
  } vec_t;

  localparam int NUM_VECS = 11;
  vec_t vecs [NUM_VECS];

  // Inputs change just after the falling edge; outputs are sampled 2 ns later,
  // which is still before the next rising edge, so they reflect current state.
  task automatic applyStimulus(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                               input logic [3:0] ss, input logic [31:0] la, input logic mr);
    @(negedge clock);
    store_valid_s1   = sv;
    store_address_s1 = sa;
    store_data_s1    = sd;
    store_strobe_s1  = ss;
    load_address_s1  = la;
    mem_ready        = mr;
    #2;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCount++;
    if (act === exp) begin
      passedCount++;
    end else begin
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic eReady, input logic eHaz, input logic eReq,
                          input logic [31:0] eAddr, input logic [31:0] eData,
                          input logic [3:0] eStrb, input logic eEmpty);
    checkOutput({tag, ".ready"},  32'(store_ready_s1),    32'(eReady));
    checkOutput({tag, ".hazard"}, 32'(load_hazard_s1),    32'(eHaz));
    checkOutput({tag, ".req"},    32'(mem_write_request), 32'(eReq));
    checkOutput({tag, ".addr"},   mem_address,            eAddr);
    checkOutput({tag, ".data"},   mem_write_data,         eData);
    checkOutput({tag, ".strb"},   32'(mem_write_strobe),  32'(eStrb));
    checkOutput({tag, ".empty"},  32'(buffer_empty),      32'(eEmpty));
  endtask

  initial begin
    logic [31:0] drainAddr [4];
    logic [31:0] drainData [4];

    // sv, sa, sd, ss, la, mr | ready, haz, req, addr, data, strb, empty
    vecs[0]  = '{1'b0, 32'h0,    32'h0,        4'h0, 32'h0,    1'b0, 1'b1, 1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 1'b1};
    vecs[1]  = '{1'b1, 32'h1003, 32'hAB000000, 4'h8, 32'h1000, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 1'b1};
    vecs[2]  = '{1'b0, 32'h0,    32'h0,        4'h0, 32'h1000, 1'b1, 1'b1, 1'b1, 1'b1, 32'h1000, 32'hAB000000, 4'h8, 1'b0};
    vecs[3]  = '{1'b0, 32'h0,    32'h0,        4'h0, 32'h1000, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 1'b1};
    vecs[4]  = '{1'b1, 32'h3000, 32'h55,       4'h0, 32'h3000, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 1'b1};
    vecs[5]  = '{1'b0, 32'h0,    32'h0,        4'h0, 32'h3000, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 1'b1};
    vecs[6]  = '{1'b1, 32'h2004, 32'h11223344, 4'hF, 32'h2006, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 1'b1};
    vecs[7]  = '{1'b0, 32'h0,    32'h0,        4'h0, 32'h2006, 1'b0, 1'b1, 1'b1, 1'b1, 32'h2004, 32'h11223344, 4'hF, 1'b0};
    vecs[8]  = '{1'b0, 32'h0,    32'h0,        4'h0, 32'h2008, 1'b0, 1'b1, 1'b0, 1'b1, 32'h2004, 32'h11223344, 4'hF, 1'b0};
    vecs[9]  = '{1'b0, 32'h0,    32'h0,        4'h0, 32'h2006, 1'b1, 1'b1, 1'b1, 1'b1, 32'h2004, 32'h11223344, 4'hF, 1'b0};
    vecs[10] = '{1'b0, 32'h0,    32'h0,        4'h0, 32'h2006, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 1'b1};

    reset_n          = 1'b0;
    store_valid_s1   = 1'b0;
    store_address_s1 = 32'h0;
    store_data_s1    = 32'h0;
    store_strobe_s1  = 4'h0;
    load_address_s1  = 32'h0;
    mem_ready        = 1'b0;
    #3;
    checkAll("reset", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    #9 reset_n = 1'b1;

    $display("[TB] vector table");
    for (int k = 0; k < NUM_VECS; k++) begin
      applyStimulus(vecs[k].sv, vecs[k].sa, vecs[k].sd, vecs[k].ss, vecs[k].la, vecs[k].mr);
      checkAll($sformatf("vec%0d", k), vecs[k].eReady, vecs[k].eHaz, vecs[k].eReq,
               vecs[k].eAddr, vecs[k].eData, vecs[k].eStrb, vecs[k].eEmpty);
    end

    $display("[TB] fill, full push+pop, wrapped drain");
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 32'h100 + 32'(4 * k), 32'(k), 4'hF, 32'h0, 1'b0);
      checkOutput($sformatf("fill%0d.ready", k), 32'(store_ready_s1), (k < 4) ? 32'h1 : 32'h0);
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 32'h110, 1'b0);
    checkAll("full.idle", 1'b0, 1'b0, 1'b1, 32'h100, 32'h0, 4'hF, 1'b0);
    applyStimulus(1'b1, 32'h200, 32'hAA, 4'hF, 32'h200, 1'b1);
    checkAll("full.pushpop", 1'b0, 1'b0, 1'b1, 32'h100, 32'h0, 4'hF, 1'b0);
    applyStimulus(1'b1, 32'h200, 32'hAA, 4'hF, 32'h0, 1'b0);
    checkAll("after.pop", 1'b1, 1'b0, 1'b1, 32'h104, 32'h1, 4'hF, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0);
    checkAll("refull", 1'b0, 1'b0, 1'b1, 32'h104, 32'h1, 4'hF, 1'b0);

    drainAddr = '{32'h104, 32'h108, 32'h10C, 32'h200};
    drainData = '{32'h1, 32'h2, 32'h3, 32'hAA};
    for (int j = 0; j < 4; j++) begin
      applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 32'h200, 1'b1);
      checkOutput($sformatf("drain%0d.req", j),    32'(mem_write_request), 32'h1);
      checkOutput($sformatf("drain%0d.addr", j),   mem_address,            drainAddr[j]);
      checkOutput($sformatf("drain%0d.data", j),   mem_write_data,         drainData[j]);
      checkOutput($sformatf("drain%0d.hazard", j), 32'(load_hazard_s1),    32'h1);
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 32'h200, 1'b1);
    checkAll("drained", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);

    $display("[TB] reset mid-drain");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 32'h500 + 32'(4 * k), 32'hC0 + 32'(k), 4'h3, 32'h0, 1'b0);
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 32'h504, 1'b0);
    checkAll("pending3", 1'b1, 1'b1, 1'b1, 32'h500, 32'hC0, 4'h3, 1'b0);
    reset_n = 1'b0;
    #1;
    checkAll("midreset", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    store_valid_s1   = 1'b1;
    store_address_s1 = 32'h4000;
    store_data_s1    = 32'h77;
    store_strobe_s1  = 4'h1;
    mem_ready        = 1'b0;
    #1 reset_n = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 32'h504, 1'b1);
    checkAll("firstpush", 1'b1, 1'b0, 1'b1, 32'h4000, 32'h77, 4'h1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 32'h504, 1'b1);
      checkOutput($sformatf("postreset%0d.req", k),   32'(mem_write_request), 32'h0);
      checkOutput($sformatf("postreset%0d.empty", k), 32'(buffer_empty),      32'h1);
    end

    $display("%0d/%0d checks passed", passedCount, totalCount);
    $finish;
  end

endmodule
